// File: rtl/adder_sched_pkg.sv
// Shared constants, ID-width helper and pipeline stage type for the adder scheduler.
// Stage fields are sized for the widest supported configuration (NREQ<=16, DSIZE<=64).
package adder_sched_pkg;

   localparam int DEF_DSIZE  = 64;
   localparam int DEF_NREQ   = 4;
   localparam int DEF_FDEPTH = 4;
   localparam int MAX_IDW    = 4;
   localparam int MAX_DSIZE  = 64;

   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [MAX_IDW-1:0]   id;
      logic [MAX_DSIZE-1:0] sum;
   } s1_t;

endpackage

// File: rtl/rr_arb.sv
// Rotating-priority arbiter: grants the first valid requester at or after ptr.
// ptr moves past the winner only when the caller signals that the grant was taken.
module rr_arb
   import adder_sched_pkg::*;
#(
   parameter  int NREQ = DEF_NREQ,
   localparam int IDW  = id_width(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] valid,
   input  logic            advance,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            grant_any
);

   logic [IDW-1:0] ptr;

   always_comb begin : search
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!grant_any && valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IDW'(idx);
            grant_any  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && grant_any) begin
         ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
      end
   end

endmodule

// File: rtl/adder_sched.sv
// Shares one 4-operand, 2-stage adder among NREQ requesters with a credit-guarded result FIFO.
// Optional statistics counters are built when ADDER_SCHED_STATS_EN is defined.
module adder_sched
   import adder_sched_pkg::*;
#(
   parameter  int DSIZE  = DEF_DSIZE,
   parameter  int NREQ   = DEF_NREQ,
   parameter  int FDEPTH = DEF_FDEPTH,
   localparam int IDW    = id_width(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*DSIZE-1:0] req_a,
   input  logic [NREQ*DSIZE-1:0] req_b,
   input  logic [NREQ*DSIZE-1:0] req_c,
   input  logic [NREQ*DSIZE-1:0] req_d,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DSIZE-1:0]      rsp_sum,
   output logic [IDW-1:0]        rsp_id
`ifdef ADDER_SCHED_STATS_EN
   ,
   output logic [31:0]           stat_issued,
   output logic [31:0]           stat_blocked
`endif
);

   localparam int PW = $clog2(FDEPTH);

   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic             has_credit;
   logic             issue_ok;
   logic             handshake;
   logic             push;
   logic             pop;
   logic [PW:0]      count;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   s1_t              s1;
   s1_t              mem [FDEPTH];
   s1_t              head;
   logic [$bits(s1_t)-1:0] head_unused;
   logic [DSIZE-1:0] sel_a, sel_b, sel_c, sel_d;
   logic [DSIZE-1:0] sum_ab, sum_cd, sum_all;

   // Credit counts only registered state, so rsp_ready never reaches req_ready combinationally.
   assign has_credit = (int'(count) + int'(s1.valid)) < FDEPTH;
   assign issue_ok   = !rst && has_credit;
   assign handshake  = issue_ok && grant_any;
   assign req_ready  = issue_ok ? grant : '0;

   rr_arb #(.NREQ(NREQ)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (req_valid),
      .advance   (issue_ok),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   always_comb begin
      sel_a   = req_a[int'(grant_idx)*DSIZE +: DSIZE];
      sel_b   = req_b[int'(grant_idx)*DSIZE +: DSIZE];
      sel_c   = req_c[int'(grant_idx)*DSIZE +: DSIZE];
      sel_d   = req_d[int'(grant_idx)*DSIZE +: DSIZE];
      sum_ab  = sel_a + sel_b;
      sum_cd  = sel_c + sel_d;
      sum_all = sum_ab + sum_cd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
      end else begin
         s1.valid <= handshake;
         s1.id    <= MAX_IDW'(grant_idx);
         s1.sum   <= MAX_DSIZE'(sum_all);
      end
   end

   assign push = s1.valid;
   assign pop  = rsp_valid && rsp_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Outputs are forced to zero while empty so stale storage never shows after reset.
   assign head        = mem[rd_ptr];
   assign head_unused = head;
   assign rsp_valid   = (count != '0);
   assign rsp_sum     = rsp_valid ? head.sum[DSIZE-1:0] : '0;
   assign rsp_id      = rsp_valid ? head.id[IDW-1:0]    : '0;

`ifdef ADDER_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued  <= '0;
         stat_blocked <= '0;
      end else begin
         if (handshake && stat_issued != '1)
            stat_issued <= stat_issued + 32'd1;
         if ((|req_valid) && !has_credit && stat_blocked != '1)
            stat_blocked <= stat_blocked + 32'd1;
      end
   end
`endif

endmodule
